mux_n_to_one_reg: RTL and testbench

Parametrised, registered N-to-1 operand multiplexer for the multiplier datapath; successor to the fixed 3-input combinational mux.
- Generalises input count (N) and width (WIDTH).
- Adds a 1-cycle registered output with valid/ready backpressure, an out-of-range select error flag, and an automatic scan mode that steps through all inputs in order.

---
 rtl/mux_n_to_one_reg_pkg.sv | 20 ++
 rtl/mux_n_to_one_reg_if.sv | 35 +++
 rtl/mux_n_to_one_reg_contador_mod_n.sv | 44 ++++
 rtl/mux_n_to_one_reg.sv | 106 ++++++++++
 tb/tb_mux_n_to_one_reg.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_to_one_reg_pkg.sv
// ----------------------------------------------------------------------------
// mult_defs
// Shared definitions for the multiplier datapath operand muxes.
//   MODO_DIRETO / MODO_VARREDURA : encodings of the 'modo' input
//   DEFAULT_WIDTH                : default operand width of the datapath
//   sel_width()                  : select/index width for an N-input mux
// ----------------------------------------------------------------------------
package mult_defs;

    localparam logic MODO_DIRETO    = 1'b0;
    localparam logic MODO_VARREDURA = 1'b1;

    localparam int DEFAULT_WIDTH = 10;

    // A 1-input mux would give $clog2(1) = 0; keep at least one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_to_one_reg_if.sv
// ----------------------------------------------------------------------------
// mux_n_to_one_reg_if
// Capture/handshake bundle of the registered N-to-1 operand mux.
//   en, modo, op, entradas, pronto : driven by the master (upstream/downstream)
//   saida, valido, indice, erro    : driven by the slave (the mux)
// ----------------------------------------------------------------------------
interface mux_n_to_one_reg_if
    import mult_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = 3
);
    localparam int SEL_W = sel_width(N);

    logic               en;
    logic               modo;
    logic [SEL_W-1:0]   op;
    logic [N*WIDTH-1:0] entradas;
    logic               pronto;
    logic [WIDTH-1:0]   saida;
    logic               valido;
    logic [SEL_W-1:0]   indice;
    logic               erro;

    modport master (
        output en, modo, op, entradas, pronto,
        input  saida, valido, indice, erro
    );

    modport slave (
        input  en, modo, op, entradas, pronto,
        output saida, valido, indice, erro
    );

endinterface

// File: rtl/mux_n_to_one_reg_contador_mod_n.sv
// ----------------------------------------------------------------------------
// contador_mod_n
// Modulo-N index counter used by the scan mode.
//   clock, reset_n : clock and asynchronous active-low reset
//   clr            : synchronous clear to 0 (has priority over inc)
//   inc            : advance by one, wrapping N-1 -> 0
//   cnt            : current count
// ----------------------------------------------------------------------------
module contador_mod_n
    import mult_defs::*;
#(
    parameter int N = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    inc,
    output logic [sel_width(N)-1:0] cnt
);
    localparam int SEL_W = sel_width(N);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == SEL_W'(N - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mux_n_to_one_reg.sv
// ----------------------------------------------------------------------------
// mux_n_to_one_reg
// Registered N-to-1 operand mux with valid/ready output, out-of-range select
// flag and an automatic scan mode stepping through all inputs in order.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mux_n_to_one_reg_if
//             (en/modo/op/entradas/pronto in, saida/valido/indice/erro out)
// All outputs are flops; no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module mux_n_to_one_reg
    import mult_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    mux_n_to_one_reg_if.slave  bus
);
    localparam int SEL_W  = sel_width(N);
    localparam int SEL_W1 = SEL_W + 1;

    logic [WIDTH-1:0] in_arr [N];
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic             in_range;
    logic             cap;
    logic             scan;

    logic [WIDTH-1:0] saida_q,  saida_d;
    logic             valido_q, valido_d;
    logic [SEL_W-1:0] indice_q, indice_d;
    logic             erro_q,   erro_d;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign in_arr[gi] = bus.entradas[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A held, unconsumed beat blocks capture; a consumed one can be replaced
    // in the same cycle.
    assign cap  = bus.en & (~valido_q | bus.pronto);
    assign scan = (bus.modo == MODO_VARREDURA);
    assign sel  = scan ? cnt : bus.op;

    // Extra bit so the comparison also works when N is a power of two.
    assign in_range = ({1'b0, sel} < SEL_W1'(N));

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_data = in_arr[i];
            end
        end
    end

    // Direct captures park the counter at 0 so that a later switch to scan
    // always starts from input 0.
    contador_mod_n #(.N(N)) u_contador (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cap & ~scan),
        .inc     (cap &  scan),
        .cnt     (cnt)
    );

    always_comb begin
        saida_d  = saida_q;
        valido_d = valido_q;
        indice_d = indice_q;
        erro_d   = erro_q;
        if (cap) begin
            valido_d = 1'b1;
            indice_d = sel;
            saida_d  = in_range ? sel_data : '0;
            erro_d   = ~in_range;
        end else if (bus.pronto) begin
            // Beat consumed with nothing new to take: data stays, valid drops.
            valido_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida_q  <= '0;
            valido_q <= 1'b0;
            indice_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            saida_q  <= saida_d;
            valido_q <= valido_d;
            indice_q <= indice_d;
            erro_q   <= erro_d;
        end
    end

    assign bus.saida  = saida_q;
    assign bus.valido = valido_q;
    assign bus.indice = indice_q;
    assign bus.erro   = erro_q;

endmodule

// File: tb/tb_mux_n_to_one_reg.sv
// ----------------------------------------------------------------------------
// tb_mux_n_to_one_reg
// Drives two instances (WIDTH=10/N=3 and WIDTH=16/N=4) with identical control
// and compares both against a behavioural model and a queue of expected beats.
// ----------------------------------------------------------------------------
module tb_mux_n_to_one_reg;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       en     = 1'b0;
    logic       modo   = 1'b0;
    logic [1:0] op     = 2'd0;
    logic       pronto = 1'b0;
    logic [15:0] in_val [2][4];

    mux_n_to_one_reg_if #(.WIDTH(10), .N(3)) bus_a ();
    mux_n_to_one_reg_if #(.WIDTH(16), .N(4)) bus_b ();

    mux_n_to_one_reg #(.WIDTH(10), .N(3)) dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
    mux_n_to_one_reg #(.WIDTH(16), .N(4)) dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

    assign bus_a.en = en;      assign bus_b.en = en;
    assign bus_a.modo = modo;  assign bus_b.modo = modo;
    assign bus_a.op = op;      assign bus_b.op = op;
    assign bus_a.pronto = pronto; assign bus_b.pronto = pronto;
    assign bus_a.entradas = {in_val[0][2][9:0], in_val[0][1][9:0], in_val[0][0][9:0]};
    assign bus_b.entradas = {in_val[1][3], in_val[1][2], in_val[1][1], in_val[1][0]};

    logic [15:0] obs_saida [2];
    logic        obs_valid [2];
    logic [1:0]  obs_idx   [2];
    logic        obs_err   [2];
    assign obs_saida[0] = {6'd0, bus_a.saida}; assign obs_saida[1] = bus_b.saida;
    assign obs_valid[0] = bus_a.valido;        assign obs_valid[1] = bus_b.valido;
    assign obs_idx[0]   = bus_a.indice;        assign obs_idx[1]   = bus_b.indice;
    assign obs_err[0]   = bus_a.erro;          assign obs_err[1]   = bus_b.erro;

    // Model state; expected beat packing is {saida[15:0], indice[1:0], erro}.
    int          nk [2] = '{3, 4};
    logic        m_valid [2];
    int          m_cnt   [2];
    logic        newcap  [2];
    logic [18:0] cur     [2];
    logic [18:0] sb_a [$];
    logic [18:0] sb_b [$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic set_inputs(input int a0, input int a1, input int a2, input int a3);
        for (int k = 0; k < 2; k++) begin
            in_val[k][0] = 16'(a0); in_val[k][1] = 16'(a1);
            in_val[k][2] = 16'(a2); in_val[k][3] = 16'(a3);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_cnt[k] = 0; newcap[k] = 1'b0; cur[k] = '0;
        end
        sb_a.delete();
        sb_b.delete();
    endtask

    // One clock: model reacts to the inputs sampled at the edge, expected
    // beats are queued, then time advances past the edge for sampling.
    task automatic tick();
        logic [15:0] d;
        logic [1:0]  ix;
        logic        er;
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            newcap[k] = 1'b0;
            if (reset_n && en && (!m_valid[k] || pronto)) begin
                if (modo) begin
                    ix = 2'(m_cnt[k]); d = in_val[k][m_cnt[k]]; er = 1'b0;
                    m_cnt[k] = (m_cnt[k] == nk[k] - 1) ? 0 : m_cnt[k] + 1;
                end else begin
                    ix = op;
                    if (int'(op) < nk[k]) begin d = in_val[k][op]; er = 1'b0; end
                    else begin d = 16'd0; er = 1'b1; end
                    m_cnt[k] = 0;
                end
                m_valid[k] = 1'b1;
                newcap[k]  = 1'b1;
                if (k == 0) sb_a.push_back({d, ix, er});
                else        sb_b.push_back({d, ix, er});
            end else if (reset_n && pronto) begin
                m_valid[k] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; modo = 1'b1; pronto = 1'b1;
        reset_model();
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({obs_saida[k], obs_valid[k], obs_idx[k], obs_err[k]} !== 20'd0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got saida=%0d valido=%b indice=%0d erro=%b want all 0",
                         k, obs_saida[k], obs_valid[k], obs_idx[k], obs_err[k]);
            end
        end
        en = 1'b0; modo = 1'b0;
        #3 reset_n = 1'b1;
    endtask

    task automatic test_direct();
        logic [18:0] e;
        int lit [3] = '{25, 42, 666};
        en = 1'b1; modo = 1'b0; pronto = 1'b1;
        for (int s = 0; s < 3; s++) begin
            op = 2'(s);
            tick();
            for (int k = 0; k < 2; k++) begin
                if (newcap[k]) begin
                    if (k == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                    cur[k] = e;
                end
                vectors++;
                if ({obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k]} !== {cur[k], m_valid[k]}) begin
                    miscompares++;
                    $display("FAIL direct dut%0d step%0d: got saida=%0d indice=%0d erro=%b valido=%b want saida=%0d indice=%0d erro=%b valido=%b",
                             k, s, obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k], cur[k][18:3], cur[k][2:1], cur[k][0], m_valid[k]);
                end
                vectors++;
                if (obs_saida[k] !== 16'(lit[s]) || obs_idx[k] !== 2'(s)) begin
                    miscompares++;
                    $display("FAIL direct_lit dut%0d step%0d: got saida=%0d indice=%0d want saida=%0d indice=%0d",
                             k, s, obs_saida[k], obs_idx[k], lit[s], s);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [18:0] e;
        logic [1:0] ops [2] = '{2'd3, 2'd1};
        en = 1'b1; modo = 1'b0; pronto = 1'b1;
        for (int s = 0; s < 2; s++) begin
            op = ops[s];
            tick();
            for (int k = 0; k < 2; k++) begin
                if (newcap[k]) begin
                    if (k == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                    cur[k] = e;
                end
                vectors++;
                if ({obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k]} !== {cur[k], m_valid[k]}) begin
                    miscompares++;
                    $display("FAIL out_of_range dut%0d step%0d: got saida=%0d indice=%0d erro=%b valido=%b want saida=%0d indice=%0d erro=%b valido=%b",
                             k, s, obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k], cur[k][18:3], cur[k][2:1], cur[k][0], m_valid[k]);
                end
            end
            if (s == 0) begin
                vectors++;
                if (obs_err[0] !== 1'b1 || obs_saida[0] !== 16'd0 || obs_valid[0] !== 1'b1 || obs_idx[0] !== 2'd3) begin
                    miscompares++;
                    $display("FAIL out_of_range_lit dut0: got erro=%b saida=%0d valido=%b indice=%0d want erro=1 saida=0 valido=1 indice=3",
                             obs_err[0], obs_saida[0], obs_valid[0], obs_idx[0]);
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [18:0] e;
        int lit [2][7] = '{'{25, 42, 666, 25, 42, 666, 25}, '{25, 42, 666, 999, 25, 42, 666}};
        en = 1'b1; modo = 1'b1; pronto = 1'b1;
        for (int s = 0; s < 7; s++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (newcap[k]) begin
                    if (k == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                    cur[k] = e;
                end
                vectors++;
                if ({obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k]} !== {cur[k], m_valid[k]}) begin
                    miscompares++;
                    $display("FAIL scan dut%0d step%0d: got saida=%0d indice=%0d erro=%b valido=%b want saida=%0d indice=%0d erro=%b valido=%b",
                             k, s, obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k], cur[k][18:3], cur[k][2:1], cur[k][0], m_valid[k]);
                end
                vectors++;
                if (obs_saida[k] !== 16'(lit[k][s]) || obs_idx[k] !== 2'(s % nk[k])) begin
                    miscompares++;
                    $display("FAIL scan_lit dut%0d step%0d: got saida=%0d indice=%0d want saida=%0d indice=%0d",
                             k, s, obs_saida[k], obs_idx[k], lit[k][s], s % nk[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] e;
        logic st_modo   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic st_pronto [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int   lit       [7] = '{25, 25, 42, 42, 42, 42, 666};
        en = 1'b1; op = 2'd0;
        for (int s = 0; s < 7; s++) begin
            modo = st_modo[s]; pronto = st_pronto[s];
            tick();
            for (int k = 0; k < 2; k++) begin
                if (newcap[k]) begin
                    if (k == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                    cur[k] = e;
                end
                vectors++;
                if ({obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k]} !== {cur[k], m_valid[k]}) begin
                    miscompares++;
                    $display("FAIL backpressure dut%0d step%0d: got saida=%0d indice=%0d erro=%b valido=%b want saida=%0d indice=%0d erro=%b valido=%b",
                             k, s, obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k], cur[k][18:3], cur[k][2:1], cur[k][0], m_valid[k]);
                end
                vectors++;
                if (obs_saida[k] !== 16'(lit[s]) || obs_valid[k] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL backpressure_lit dut%0d step%0d: got saida=%0d valido=%b want saida=%0d valido=1",
                             k, s, obs_saida[k], obs_valid[k], lit[s]);
                end
            end
        end
    endtask

    task automatic test_drain_stability();
        logic [18:0] e;
        logic st_en  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic lit_v  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        modo = 1'b0; pronto = 1'b1; op = 2'd2;
        for (int s = 0; s < 5; s++) begin
            en = st_en[s];
            if (s == 3) begin
                set_inputs(50, 84, 777, 1000);
                op = 2'd0;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (newcap[k]) begin
                    if (k == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                    cur[k] = e;
                end
                vectors++;
                if ({obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k]} !== {cur[k], m_valid[k]}) begin
                    miscompares++;
                    $display("FAIL drain dut%0d step%0d: got saida=%0d indice=%0d erro=%b valido=%b want saida=%0d indice=%0d erro=%b valido=%b",
                             k, s, obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k], cur[k][18:3], cur[k][2:1], cur[k][0], m_valid[k]);
                end
                if (s >= 1) begin
                    vectors++;
                    if (obs_saida[k] !== 16'd666 || obs_valid[k] !== lit_v[s]) begin
                        miscompares++;
                        $display("FAIL drain_lit dut%0d step%0d: got saida=%0d valido=%b want saida=666 valido=%b",
                                 k, s, obs_saida[k], obs_valid[k], lit_v[s]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] e;
        int lit [2] = '{25, 42};
        set_inputs(25, 42, 666, 999);
        en = 1'b1; modo = 1'b1; pronto = 1'b1;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin while (sb_a.size() > 0) e = sb_a.pop_front(); end
            else        begin while (sb_b.size() > 0) e = sb_b.pop_front(); end
        end
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({obs_saida[k], obs_valid[k], obs_idx[k], obs_err[k]} !== 20'd0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got saida=%0d valido=%b indice=%0d erro=%b want all 0",
                         k, obs_saida[k], obs_valid[k], obs_idx[k], obs_err[k]);
            end
        end
        reset_model();
        #2 reset_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (newcap[k]) begin
                    if (k == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                    cur[k] = e;
                end
                vectors++;
                if ({obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k]} !== {cur[k], m_valid[k]}) begin
                    miscompares++;
                    $display("FAIL restart dut%0d step%0d: got saida=%0d indice=%0d erro=%b valido=%b want saida=%0d indice=%0d erro=%b valido=%b",
                             k, s, obs_saida[k], obs_idx[k], obs_err[k], obs_valid[k], cur[k][18:3], cur[k][2:1], cur[k][0], m_valid[k]);
                end
                vectors++;
                if (obs_saida[k] !== 16'(lit[s]) || obs_idx[k] !== 2'(s)) begin
                    miscompares++;
                    $display("FAIL restart_lit dut%0d step%0d: got saida=%0d indice=%0d want saida=%0d indice=%0d",
                             k, s, obs_saida[k], obs_idx[k], lit[s], s);
                end
            end
        end
    endtask

    initial begin
        set_inputs(25, 42, 666, 999);
        reset_model();
        test_reset();
        test_direct();
        test_out_of_range();
        test_scan();
        test_backpressure();
        test_drain_stability();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
